// File: rtl/useq_stack.sv
// Microsequencer: next micro-address from NEXT/IRD/CALL/RET, optional return stack (USEQ_STACK_EN).
// Latency: uaddr registers ns one cycle after the sequencing inputs are sampled.
// Stall: hold freezes uaddr and the stack; overflow/underflow never stall, they set sticky flags.
module useq_stack #(
    parameter int UADDR_W     = 6,
    parameter int COND_W      = 3,
    parameter int NQUAL       = 5,
    parameter logic [NQUAL*$clog2(UADDR_W)-1:0] QBIT_MAP = {3'd4, 3'd3, 3'd0, 3'd2, 3'd1},
    parameter int OPC_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 18
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic                               hold,
    input  logic [1:0]                         seq_op,
    input  logic [COND_W-1:0]                  cond,
    input  logic [UADDR_W-1:0]                 j,
    input  logic [OPC_W-1:0]                   opcode,
    input  logic [NQUAL-1:0]                   qual,
    input  logic                               err_clr,
    output logic [UADDR_W-1:0]                 uaddr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               err_ovf,
    output logic                               err_unf
);
    localparam int QB_W    = $clog2(UADDR_W);
    localparam int DEPTH_W = $clog2(STACK_DEPTH+1);

    localparam logic [1:0] OP_NEXT = 2'd0;
    localparam logic [1:0] OP_IRD  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    logic [UADDR_W-1:0] r_uaddr;
    logic [UADDR_W-1:0] w_tgt;
    logic [UADDR_W-1:0] w_opc_ext;
    logic [UADDR_W-1:0] w_ns;

    // cond 0 or out of range leaves the J field untouched
    always_comb begin
        w_tgt = j;
        for (int k = 1; k <= NQUAL; k++) begin
            if (cond == COND_W'(k)) begin
                w_tgt = j | (UADDR_W'(qual[k-1]) << QBIT_MAP[(k-1)*QB_W +: QB_W]);
            end
        end
    end

    assign w_opc_ext = UADDR_W'(opcode);

`ifdef USEQ_STACK_EN
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [UADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic               r_empty;
    logic               r_full;
    logic               r_ovf;
    logic               r_unf;

    logic               w_push;
    logic               w_pop;
    logic               w_ovf_new;
    logic               w_unf_new;
    logic [PTR_W-1:0]   w_push_idx;
    logic [PTR_W-1:0]   w_top_idx;
    logic [DEPTH_W-1:0] w_depth_nxt;
    logic [UADDR_W-1:0] w_ret_addr;

    assign w_push     = !hold && (seq_op == OP_CALL) && !r_full;
    assign w_pop      = !hold && (seq_op == OP_RET)  && !r_empty;
    assign w_ovf_new  = !hold && (seq_op == OP_CALL) && r_full;
    assign w_unf_new  = !hold && (seq_op == OP_RET)  && r_empty;
    assign w_push_idx = PTR_W'(r_depth);
    assign w_top_idx  = PTR_W'(r_depth - 1'b1);
    assign w_ret_addr = r_uaddr + 1'b1;

    always_comb begin
        w_depth_nxt = r_depth;
        if (w_push) begin
            w_depth_nxt = r_depth + 1'b1;
        end else if (w_pop) begin
            w_depth_nxt = r_depth - 1'b1;
        end
    end

    always_comb begin
        w_ns = w_tgt;
        case (seq_op)
            OP_NEXT: w_ns = w_tgt;
            OP_IRD:  w_ns = w_opc_ext;
            OP_CALL: w_ns = w_tgt;
            OP_RET:  w_ns = r_empty ? j : r_stack[w_top_idx];
            default: w_ns = w_tgt;
        endcase
    end

    // Storage needs no reset: entries above depth are never read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_ret_addr;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_depth <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_depth <= w_depth_nxt;
            r_empty <= (w_depth_nxt == '0);
            r_full  <= (w_depth_nxt == DEPTH_W'(STACK_DEPTH));
            r_ovf   <= (r_ovf && !err_clr) || w_ovf_new;
            r_unf   <= (r_unf && !err_clr) || w_unf_new;
        end
    end

    assign depth       = r_depth;
    assign stack_empty = r_empty;
    assign stack_full  = r_full;
    assign err_ovf     = r_ovf;
    assign err_unf     = r_unf;
`else
    logic w_unused;

    always_comb begin
        w_ns = w_tgt;
        case (seq_op)
            OP_NEXT: w_ns = w_tgt;
            OP_IRD:  w_ns = w_opc_ext;
            OP_CALL: w_ns = w_tgt;
            OP_RET:  w_ns = w_tgt;
            default: w_ns = w_tgt;
        endcase
    end

    assign w_unused    = &{1'b0, err_clr};
    assign depth       = '0;
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign err_ovf     = 1'b0;
    assign err_unf     = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_uaddr <= UADDR_W'(RESET_ADDR);
        end else if (!hold) begin
            r_uaddr <= w_ns;
        end
    end

    assign uaddr = r_uaddr;

endmodule
